// File: rtl/execute_stage_mdu.sv
// RV32IM execute stage: ALU, branch compare, jump/JALR target, iterative
// multiply/divide unit that stalls the front end, and the EX/MEM register.
module execute_stage_mdu #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ValidE,
  input  logic [XLEN-1:0] RD1_E,
  input  logic [XLEN-1:0] RD2_E,
  input  logic [XLEN-1:0] PCE,
  input  logic [XLEN-1:0] Imm_ExtE,
  input  logic [XLEN-1:0] PCPlus4E,
  input  logic [4:0]      RdE,
  input  logic            RegWriteE,
  input  logic            MemWriteE,
  input  logic            JumpE,
  input  logic            JalrE,
  input  logic            BranchE,
  input  logic            ALUSrcE,
  input  logic            MDUE,
  input  logic [1:0]      ResultSrcE,
  input  logic [2:0]      Funct3E,
  input  logic [3:0]      ALU_CtrlE,
  output logic            RegWriteM,
  output logic            MemWriteM,
  output logic [1:0]      ResultSrcM,
  output logic [XLEN-1:0] ALUResultM,
  output logic [XLEN-1:0] WriteDataM,
  output logic [XLEN-1:0] PCPlus4M,
  output logic [4:0]      RdM,
  output logic            StallE,
  output logic            PCSrcE,
  output logic [XLEN-1:0] PCTargetE
);

  // state | meaning
  // IDLE  | no MDU op in flight; a new one may start this cycle
  // BUSY  | one shift-add / restoring-divide iteration per cycle
  // DONE  | result valid, captured into EX/MEM at the end of this cycle
  typedef enum logic [1:0] {IDLE, BUSY, DONE} mdu_state_t;

  localparam int SHW = $clog2(XLEN);
  localparam int CW  = $clog2(XLEN + 1);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  mdu_state_t state_q, state_d;

  logic [XLEN-1:0]   src_b, alu_result, jalr_sum, mdu_result;
  logic [SHW-1:0]    shamt;
  logic              cond;

  logic [2*XLEN-1:0] acc_q, mul_step, div_step, prod_fix;
  logic [XLEN-1:0]   opb_q, quo_fix, rem_fix, a_mag, b_mag;
  logic [XLEN:0]     mul_sum, div_shift, div_diff;
  logic [CW-1:0]     cnt_q;
  logic [2:0]        op_q;
  logic              neg_res_q, neg_rem_q;
  logic              start, is_div, div_signed, a_signed, b_signed, a_neg, b_neg;
  logic              div_by_zero, div_ovf, special;

  assign src_b = ALUSrcE ? Imm_ExtE : RD2_E;
  assign shamt = src_b[SHW-1:0];

  // ALU
  always_comb begin
    alu_result = '0;
    case (ALU_CtrlE)
      4'd0: alu_result = RD1_E + src_b;
      4'd1: alu_result = RD1_E - src_b;
      4'd2: alu_result = RD1_E & src_b;
      4'd3: alu_result = RD1_E | src_b;
      4'd4: alu_result = RD1_E ^ src_b;
      4'd5: alu_result = {{(XLEN-1){1'b0}}, $signed(RD1_E) < $signed(src_b)};
      4'd6: alu_result = {{(XLEN-1){1'b0}}, RD1_E < src_b};
      4'd7: alu_result = RD1_E << shamt;
      4'd8: alu_result = RD1_E >> shamt;
      4'd9: alu_result = $signed(RD1_E) >>> shamt;
      default: alu_result = '0;
    endcase
  end

  // branch condition
  always_comb begin
    cond = 1'b0;
    case (Funct3E)
      3'b000: cond = (RD1_E == RD2_E);
      3'b001: cond = (RD1_E != RD2_E);
      3'b100: cond = ($signed(RD1_E) < $signed(RD2_E));
      3'b101: cond = ($signed(RD1_E) >= $signed(RD2_E));
      3'b110: cond = (RD1_E < RD2_E);
      3'b111: cond = (RD1_E >= RD2_E);
      default: cond = 1'b0;
    endcase
  end

  assign jalr_sum  = RD1_E + Imm_ExtE;
  assign PCTargetE = JalrE ? {jalr_sum[XLEN-1:1], 1'b0} : (PCE + Imm_ExtE);
  assign PCSrcE    = ValidE & (JumpE | (BranchE & cond));

  // MDU operand decode: magnitudes, signs and the two divide special cases
  assign start       = ValidE & MDUE;
  assign is_div      = Funct3E[2];
  assign div_signed  = is_div & ~Funct3E[0];
  assign a_signed    = is_div ? div_signed : (Funct3E[1:0] == 2'd1 || Funct3E[1:0] == 2'd2);
  assign b_signed    = is_div ? div_signed : (Funct3E[1:0] == 2'd1);
  assign a_neg       = a_signed & RD1_E[XLEN-1];
  assign b_neg       = b_signed & RD2_E[XLEN-1];
  assign a_mag       = a_neg ? -RD1_E : RD1_E;
  assign b_mag       = b_neg ? -RD2_E : RD2_E;
  assign div_by_zero = is_div & (RD2_E == '0);
  assign div_ovf     = div_signed & (RD1_E == MIN_NEG) & (&RD2_E);
  assign special     = div_by_zero | div_ovf;

  // Multiply: low half of acc holds the multiplier, upper half accumulates.
  // Divide: upper half is the partial remainder, lower half shifts the
  // dividend out and the quotient bits in.
  assign mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opb_q} : '0);
  assign mul_step  = {mul_sum, acc_q[XLEN-1:1]};
  assign div_shift = acc_q[2*XLEN-1:XLEN-1];
  assign div_diff  = div_shift - {1'b0, opb_q};
  assign div_step  = div_diff[XLEN] ? {div_shift[XLEN-1:0], acc_q[XLEN-2:0], 1'b0}
                                    : {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};

  assign prod_fix = neg_res_q ? -acc_q : acc_q;
  assign quo_fix  = neg_res_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
  assign rem_fix  = neg_rem_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];

  // MDU result select with sign correction
  always_comb begin
    mdu_result = '0;
    case (op_q)
      3'd0:             mdu_result = prod_fix[XLEN-1:0];
      3'd1, 3'd2, 3'd3: mdu_result = prod_fix[2*XLEN-1:XLEN];
      3'd4, 3'd5:       mdu_result = quo_fix;
      default:          mdu_result = rem_fix;
    endcase
  end

  // MDU FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // MDU next state and front-end stall
  always_comb begin
    state_d = state_q;
    StallE  = 1'b0;
    case (state_q)
      IDLE: begin
        StallE = start;
        if (start) state_d = special ? DONE : BUSY;
      end
      BUSY: begin
        StallE = 1'b1;
        if (cnt_q == CW'(1)) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (rst) StallE = 1'b0;
  end

  // MDU datapath: operand latch on start, one iteration per BUSY cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q     <= '0;
      opb_q     <= '0;
      cnt_q     <= '0;
      op_q      <= '0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
    end else if (state_q == IDLE && start) begin
      op_q <= Funct3E;
      if (special) begin
        // preload acc so the normal result path yields the fixed answers
        cnt_q     <= '0;
        opb_q     <= '0;
        neg_res_q <= 1'b0;
        neg_rem_q <= 1'b0;
        acc_q     <= div_by_zero ? {RD1_E, {XLEN{1'b1}}} : {{XLEN{1'b0}}, RD1_E};
      end else begin
        cnt_q     <= CW'(XLEN);
        neg_res_q <= a_neg ^ b_neg;
        neg_rem_q <= is_div & a_neg;
        if (is_div) begin
          acc_q <= {{XLEN{1'b0}}, a_mag};
          opb_q <= b_mag;
        end else begin
          acc_q <= {{XLEN{1'b0}}, b_mag};
          opb_q <= a_mag;
        end
      end
    end else if (state_q == BUSY) begin
      cnt_q <= cnt_q - CW'(1);
      acc_q <= op_q[2] ? div_step : mul_step;
    end
  end

  // EX/MEM pipeline register; a stall inserts a bubble
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      RegWriteM  <= 1'b0;
      MemWriteM  <= 1'b0;
      ResultSrcM <= '0;
      ALUResultM <= '0;
      WriteDataM <= '0;
      PCPlus4M   <= '0;
      RdM        <= '0;
    end else if (StallE) begin
      RegWriteM <= 1'b0;
      MemWriteM <= 1'b0;
    end else begin
      RegWriteM  <= RegWriteE & ValidE;
      MemWriteM  <= MemWriteE & ValidE;
      ResultSrcM <= ResultSrcE;
      ALUResultM <= (state_q == DONE) ? mdu_result : alu_result;
      WriteDataM <= RD2_E;
      PCPlus4M   <= PCPlus4E;
      RdM        <= RdE;
    end
  end

endmodule

// File: tb/tb_execute_stage_mdu.sv
// Bench for execute_stage_mdu: directed ALU/branch vectors, randomized ALU and
// MDU traffic against an arithmetic reference, and stall/reset sequences.
module tb_execute_stage_mdu;

  logic        clk = 1'b0;
  logic        rst;
  logic        ValidE;
  logic [31:0] RD1_E, RD2_E, PCE, Imm_ExtE, PCPlus4E;
  logic [4:0]  RdE;
  logic        RegWriteE, MemWriteE, JumpE, JalrE, BranchE, ALUSrcE, MDUE;
  logic [1:0]  ResultSrcE;
  logic [2:0]  Funct3E;
  logic [3:0]  ALU_CtrlE;
  logic        RegWriteM, MemWriteM;
  logic [1:0]  ResultSrcM;
  logic [31:0] ALUResultM, WriteDataM, PCPlus4M;
  logic [4:0]  RdM;
  logic        StallE, PCSrcE;
  logic [31:0] PCTargetE;

  int n_cmp = 0;
  int n_err = 0;

  execute_stage_mdu #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .ValidE(ValidE),
    .RD1_E(RD1_E), .RD2_E(RD2_E), .PCE(PCE), .Imm_ExtE(Imm_ExtE), .PCPlus4E(PCPlus4E),
    .RdE(RdE), .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .JumpE(JumpE), .JalrE(JalrE),
    .BranchE(BranchE), .ALUSrcE(ALUSrcE), .MDUE(MDUE), .ResultSrcE(ResultSrcE),
    .Funct3E(Funct3E), .ALU_CtrlE(ALU_CtrlE),
    .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .ResultSrcM(ResultSrcM),
    .ALUResultM(ALUResultM), .WriteDataM(WriteDataM), .PCPlus4M(PCPlus4M), .RdM(RdM),
    .StallE(StallE), .PCSrcE(PCSrcE), .PCTargetE(PCTargetE)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [3:0]  ctrl;
    logic        alusrc;
    logic [31:0] rd1, rd2, imm, pc;
    logic [2:0]  f3;
    logic        br, jmp, jalr, valid;
    logic [31:0] exp_alu;
    logic        exp_pcsrc;
    logic [31:0] exp_tgt;
  } vec_t;

  vec_t vecs[13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] ref_alu(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
    int sa, sb;
    logic [31:0] r;
    sa = a;
    sb = b;
    case (c)
      4'd0: r = a + b;
      4'd1: r = a - b;
      4'd2: r = a & b;
      4'd3: r = a | b;
      4'd4: r = a ^ b;
      4'd5: r = (sa < sb) ? 32'd1 : 32'd0;
      4'd6: r = (a < b) ? 32'd1 : 32'd0;
      4'd7: r = a << (b % 32);
      4'd8: r = a >> (b % 32);
      4'd9: r = 32'(sa >>> (b % 32));
      default: r = 32'd0;
    endcase
    return r;
  endfunction

  function automatic logic ref_cond(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    int sa, sb;
    sa = a;
    sb = b;
    case (f)
      3'b000: return a == b;
      3'b001: return a != b;
      3'b100: return sa < sb;
      3'b101: return sa >= sb;
      3'b110: return a < b;
      3'b111: return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic is_special(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    if (op < 3'd4) return 1'b0;
    if (b == 32'd0) return 1'b1;
    return (op == 3'd4 || op == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF;
  endfunction

  function automatic logic [31:0] ref_mdu(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb;
    longint unsigned ua, ub;
    logic [63:0] p;
    logic [31:0] r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = 64'(a);
    ub = 64'(b);
    r = 32'd0;
    case (op)
      3'd0: begin p = sa * sb;           r = p[31:0];  end
      3'd1: begin p = sa * sb;           r = p[63:32]; end
      3'd2: begin p = sa * longint'(ub); r = p[63:32]; end
      3'd3: begin p = ua * ub;           r = p[63:32]; end
      3'd4: r = (b == 0) ? 32'hFFFF_FFFF : 32'(sa / sb);
      3'd5: r = (b == 0) ? 32'hFFFF_FFFF : 32'(ua / ub);
      3'd6: r = (b == 0) ? a : 32'(sa % sb);
      default: r = (b == 0) ? a : 32'(ua % ub);
    endcase
    return r;
  endfunction

  task automatic drive_idle();
    ValidE = 0; MDUE = 0; RegWriteE = 0; MemWriteE = 0; JumpE = 0; JalrE = 0;
    BranchE = 0; ALUSrcE = 0; ResultSrcE = 0; Funct3E = 0; ALU_CtrlE = 0;
    RD1_E = 0; RD2_E = 0; PCE = 0; Imm_ExtE = 0; PCPlus4E = 0; RdE = 0;
  endtask

  // one single-cycle instruction: combinational redirect now, EX/MEM after the edge
  task automatic run_alu(input vec_t v, input logic [4:0] rd, input logic [1:0] rs, input string name);
    @(negedge clk);
    ValidE = v.valid; MDUE = 0; RegWriteE = 1; MemWriteE = 1;
    JumpE = v.jmp; JalrE = v.jalr; BranchE = v.br; ALUSrcE = v.alusrc;
    ResultSrcE = rs; Funct3E = v.f3; ALU_CtrlE = v.ctrl;
    RD1_E = v.rd1; RD2_E = v.rd2; PCE = v.pc; Imm_ExtE = v.imm; PCPlus4E = v.pc + 32'd4; RdE = rd;
    #1;
    check({name, " PCSrcE"}, 32'(PCSrcE), 32'(v.exp_pcsrc));
    check({name, " PCTargetE"}, PCTargetE, v.exp_tgt);
    check({name, " StallE"}, 32'(StallE), 32'd0);
    @(posedge clk);
    #1;
    check({name, " ALUResultM"}, ALUResultM, v.exp_alu);
    check({name, " RegWriteM"}, 32'(RegWriteM), 32'(v.valid));
    check({name, " MemWriteM/WriteDataM/PCPlus4M/RdM/ResultSrcM"},
          {31'd0, MemWriteM} ^ WriteDataM ^ PCPlus4M ^ 32'(RdM) ^ 32'(ResultSrcM),
          {31'd0, v.valid} ^ v.rd2 ^ (v.pc + 32'd4) ^ 32'(rd) ^ 32'(rs));
  endtask

  // one MDU instruction held until its result lands in EX/MEM
  task automatic run_mdu(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input string name);
    logic [31:0] exp;
    int exp_stall, stalls, wr_bad;
    bit done;
    exp = ref_mdu(op, a, b);
    exp_stall = is_special(op, a, b) ? 1 : 33;
    @(negedge clk);
    ValidE = 1; MDUE = 1; RegWriteE = 1; MemWriteE = 0; JumpE = 0; JalrE = 0;
    BranchE = 0; ALUSrcE = 0; ResultSrcE = 0; Funct3E = op; ALU_CtrlE = 0;
    RD1_E = a; RD2_E = b; PCE = 32'h40; Imm_ExtE = 0; PCPlus4E = 32'h44; RdE = 5'd7;
    stalls = 0; wr_bad = 0; done = 0;
    for (int c = 0; c < 100 && !done; c++) begin
      #1;
      if (StallE) begin
        stalls++;
        if (c > 0 && (RegWriteM || MemWriteM)) wr_bad++;
        @(negedge clk);
      end else begin
        done = 1;
      end
    end
    if (!done) begin
      n_cmp++; n_err++;
      $display("FAIL %s timeout: StallE still high after 100 cycles, required low", name);
    end
    @(posedge clk);
    #1;
    check({name, " result"}, ALUResultM, exp);
    check({name, " stall cycles"}, 32'(stalls), 32'(exp_stall));
    check({name, " writes during stall"}, 32'(wr_bad), 32'd0);
    check({name, " RegWriteM"}, 32'(RegWriteM), 32'd1);
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    vec_t rv;
    logic [31:0] srcb;

    vecs[0]  = '{4'd0, 1'b0, 32'h7FFF_FFFF, 32'h1,         32'h20,        32'h100, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h8000_0000, 1'b0, 32'h120};
    vecs[1]  = '{4'd1, 1'b0, 32'hFFFF_FFFF, 32'h1,         32'h40,        32'h200, 3'd4, 1'b1, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b1, 32'h240};
    vecs[2]  = '{4'd1, 1'b0, 32'hFFFF_FFFF, 32'h1,         32'hFFFF_FFF0, 32'h300, 3'd7, 1'b1, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b1, 32'h2F0};
    vecs[3]  = '{4'd0, 1'b1, 32'h1003,      32'h0,         32'h4,         32'h400, 3'd0, 1'b0, 1'b1, 1'b1, 1'b1, 32'h1007,      1'b1, 32'h1006};
    vecs[4]  = '{4'd2, 1'b0, 32'h5,         32'h6,         32'h8,         32'h500, 3'd0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h4,         1'b0, 32'h508};
    vecs[5]  = '{4'd9, 1'b1, 32'h8000_0000, 32'h0,         32'h4,         32'h600, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 32'hF800_0000, 1'b0, 32'h604};
    vecs[6]  = '{4'd5, 1'b0, 32'hFFFF_FFFB, 32'h3,         32'h0,         32'h700, 3'd1, 1'b1, 1'b0, 1'b0, 1'b1, 32'h1,         1'b1, 32'h700};
    vecs[7]  = '{4'd6, 1'b0, 32'hFFFF_FFFB, 32'h3,         32'h10,        32'h800, 3'd5, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0,         1'b0, 32'h810};
    vecs[8]  = '{4'd7, 1'b0, 32'h1,         32'h3F,        32'h0,         32'h900, 3'd2, 1'b1, 1'b0, 1'b0, 1'b1, 32'h8000_0000, 1'b0, 32'h900};
    vecs[9]  = '{4'd8, 1'b0, 32'h8000_0000, 32'h1F,        32'hC,         32'hA00, 3'd6, 1'b1, 1'b0, 1'b0, 1'b1, 32'h1,         1'b0, 32'hA0C};
    vecs[10] = '{4'd12,1'b0, 32'h1234_5678, 32'h9,         32'h0,         32'hB00, 3'd3, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0,         1'b0, 32'hB00};
    vecs[11] = '{4'd4, 1'b0, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h10,        32'hC00, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0FF0_0FF0, 1'b0, 32'hC10};
    vecs[12] = '{4'd3, 1'b1, 32'h0F,        32'h0F,        32'hF0,        32'hD00, 3'd0, 1'b1, 1'b0, 1'b0, 1'b1, 32'hFF,        1'b1, 32'hDF0};

    // reset state, with an MDU request present to show reset gates StallE
    drive_idle();
    rst = 1;
    ValidE = 1; MDUE = 1;
    repeat (2) @(negedge clk);
    #1;
    check("reset StallE", 32'(StallE), 32'd0);
    check("reset RegWriteM", 32'(RegWriteM), 32'd0);
    check("reset ALUResultM", ALUResultM, 32'd0);
    check("reset PCPlus4M", PCPlus4M, 32'd0);
    @(negedge clk);
    drive_idle();
    rst = 0;

    // directed ALU / branch / jump table
    for (int i = 0; i < 13; i++) run_alu(vecs[i], 5'(i + 1), 2'(i), $sformatf("vec%0d", i));

    // directed MDU corner cases (back-to-back, no idle gap between them)
    run_mdu(3'd1, 32'h8000_0000, 32'h8000_0000, "MULH min*min");
    run_mdu(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "MULHU max*max");
    run_mdu(3'd4, 32'hFFFF_FFF9, 32'd2, "DIV -7/2");
    run_mdu(3'd6, 32'hFFFF_FFF9, 32'd2, "REM -7/2");
    run_mdu(3'd5, 32'd100, 32'd7, "DIVU 100/7");
    run_mdu(3'd4, 32'd5, 32'd0, "DIV 5/0");
    run_mdu(3'd7, 32'd5, 32'd0, "REMU 5/0");
    run_mdu(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, "DIV min/-1");
    run_mdu(3'd2, 32'hFFFF_FFFE, 32'd3, "MULHSU -2*3");

    // randomized ALU / branch / jump traffic
    for (int i = 0; i < 150; i++) begin
      rv.ctrl = 4'($urandom_range(0, 15));
      rv.alusrc = 1'($urandom_range(0, 1));
      rv.rd1 = pick_operand();
      rv.rd2 = ($urandom_range(0, 3) == 0) ? rv.rd1 : pick_operand();
      rv.imm = $urandom;
      rv.pc = $urandom & 32'hFFFF_FFFC;
      rv.f3 = 3'($urandom_range(0, 7));
      rv.br = 1'($urandom_range(0, 1));
      rv.jmp = ($urandom_range(0, 3) == 0);
      rv.jalr = rv.jmp & 1'($urandom_range(0, 1));
      rv.valid = ($urandom_range(0, 5) != 0);
      srcb = rv.alusrc ? rv.imm : rv.rd2;
      rv.exp_alu = ref_alu(rv.ctrl, rv.rd1, srcb);
      rv.exp_pcsrc = rv.valid && (rv.jmp || (rv.br && ref_cond(rv.f3, rv.rd1, rv.rd2)));
      rv.exp_tgt = rv.jalr ? ((rv.rd1 + rv.imm) & 32'hFFFF_FFFE) : (rv.pc + rv.imm);
      run_alu(rv, 5'($urandom_range(0, 31)), 2'($urandom_range(0, 3)), $sformatf("rand_alu%0d", i));
    end

    // randomized MDU traffic
    for (int i = 0; i < 24; i++) begin
      logic [2:0] op;
      logic [31:0] a, b;
      op = 3'($urandom_range(0, 7));
      a = pick_operand();
      b = pick_operand();
      run_mdu(op, a, b, $sformatf("rand_mdu%0d op%0d", i, op));
    end

    // async reset in the middle of a multiply
    run_alu(vecs[0], 5'd9, 2'd1, "pre-reset");
    @(negedge clk);
    ValidE = 1; MDUE = 1; RegWriteE = 1; Funct3E = 3'd0; RD1_E = 32'd7; RD2_E = 32'd9;
    repeat (10) @(negedge clk);
    #1;
    check("BUSY cycle 10 StallE", 32'(StallE), 32'd1);
    rst = 1;
    #1;
    check("mid-op reset StallE", 32'(StallE), 32'd0);
    check("mid-op reset ALUResultM", ALUResultM, 32'd0);
    check("mid-op reset PCPlus4M", PCPlus4M, 32'd0);
    check("mid-op reset RdM", 32'(RdM), 32'd0);
    @(negedge clk);
    drive_idle();
    rst = 0;
    @(negedge clk);
    #1;
    check("post-reset idle StallE", 32'(StallE), 32'd0);
    run_mdu(3'd0, 32'd3, 32'd4, "MUL 3*4 after reset");

    @(negedge clk);
    drive_idle();
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/execute_stage_mdu.md
# execute_stage_mdu

Parametrised RV32IM execute stage with EX/MEM pipeline register. Adds to the base execute stage a full RV32I branch comparator set, JALR target generation, a 4-bit ALU control, and an iterative multiply/divide unit (MDU) that stalls the front end while it runs. It sits between the ID/EX register and the memory stage; the hazard unit consumes `StallE`.

## Interface
- `XLEN`, 32: datapath width; must be even and ≥ 8.
- `clk` in 1: clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `ValidE` in 1: EX holds a real instruction; 0 = bubble.
- `RD1_E`, `RD2_E`, `PCE`, `Imm_ExtE`, `PCPlus4E` in XLEN: operands, PC, immediate, PC+4.
- `RdE` in 5: destination register.
- `RegWriteE`, `MemWriteE`, `JumpE`, `JalrE`, `BranchE`, `ALUSrcE`, `MDUE` in 1: decoded controls.
- `ResultSrcE` in 2: result select, passed through.
- `Funct3E` in 3: branch condition or MDU op.
- `ALU_CtrlE` in 4: ALU op.
- `RegWriteM`, `MemWriteM` out 1: EX/MEM controls.
- `ResultSrcM` out 2: EX/MEM result select.
- `ALUResultM`, `WriteDataM`, `PCPlus4M` out XLEN: EX/MEM data.
- `RdM` out 5: EX/MEM destination.
- `StallE` out 1: hold PC, IF/ID and ID/EX this cycle.
- `PCSrcE` out 1: redirect fetch.
- `PCTargetE` out XLEN: redirect target.

## Operation
- SrcB is `Imm_ExtE` when `ALUSrcE` is 1, otherwise `RD2_E`.
- ALU ops: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLT, 6 SLTU, 7 SLL, 8 SRL, 9 SRA. Shift amount is SrcB[log2(XLEN)-1:0]. Codes 10–15 give 0.
- Branch condition from `Funct3E`: 000 EQ, 001 NE, 100 LT signed, 101 GE signed, 110 LTU, 111 GEU. 010 and 011 give false.
- `PCSrcE` = `ValidE` & (`JumpE` | (`BranchE` & cond)).
- `PCTargetE` = (`RD1_E` + `Imm_ExtE`) & ~1 when `JalrE` is 1, otherwise `PCE` + `Imm_ExtE`. All adds wrap modulo 2^XLEN.
- MDU ops from `Funct3E`: 0 MUL (low half), 1 MULH (s×s), 2 MULHSU (s×u), 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- Multiply is radix-2 shift-add on magnitudes with a 2·XLEN product, sign-corrected at the end.
- Divide is radix-2 restoring on magnitudes. Quotient is negated if operand signs differ. Remainder takes the dividend's sign.
- Divide special cases bypass iteration:
  - divisor 0: quotient all-ones, remainder = dividend.
  - signed −2^(XLEN−1) / −1: quotient = dividend, remainder 0.
- MDU FSM states: IDLE, BUSY, DONE.
  - IDLE → BUSY when `ValidE & MDUE` and no special case. Operands latched, counter loaded with XLEN.
  - IDLE → DONE directly when a special case is detected.
  - BUSY: one iteration per cycle, counter decrements. BUSY → DONE when the counter reaches 0 after the last iteration.
  - DONE → IDLE unconditionally.
- `StallE` = !`rst` & ((IDLE & `ValidE` & `MDUE`) | BUSY). It is 0 in DONE.
- EX/MEM register update:
  - When `StallE` is 1 it loads a bubble: `RegWriteM`, `MemWriteM` = 0; other fields are don't-care but are held.
  - Otherwise it loads the EX values. `ALUResultM` takes the MDU result in DONE, else the ALU result.
  - `WriteDataM` = `RD2_E`.
  - `RegWriteM` and `MemWriteM` are gated by `ValidE`.
- The inputs of an MDU instruction are held stable by the hazard unit while `StallE` is 1.

## Timing
- Reset (async): every registered output goes to 0, the FSM goes to IDLE, the counter clears. Reset mid-MDU abandons the operation with no result.
- ALU, branch and jump instructions: single cycle; EX/MEM updates at the next edge.
- `PCSrcE` and `PCTargetE` are combinational in the same cycle.
- MDU normal op:
  - cycle 0 (IDLE, start): `StallE` = 1.
  - cycles 1..XLEN (BUSY): `StallE` = 1.
  - cycle XLEN+1 (DONE): `StallE` = 0; result captured at that edge.
  - Total occupancy is XLEN+2 cycles; `StallE` is high for XLEN+1 of them.
- MDU special case: cycle 0 stalled, cycle 1 DONE. Occupancy 2 cycles.
- Back-to-back MDU ops: the second starts in the IDLE cycle after DONE, with no extra gap.
- DONE never restarts on the same instruction.

## Test plan
- ALU and branches: ADD 0x7FFFFFFF+1 → `ALUResultM`=0x80000000. BLT −1<1 → `PCSrcE`=1, `PCTargetE`=`PCE`+imm. BGEU 0xFFFFFFFF≥1 → `PCSrcE`=1.
- JALR: `RD1_E`=0x1003, imm=4 → `PCTargetE`=0x1006, `PCSrcE`=1, `ALUResultM`/`PCPlus4M` passed through.
- MUL family: MULH 0x80000000×0x80000000 → 0x40000000. MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE. `StallE` high for exactly 33 cycles; `RegWriteM`=0 during the stall, then a single write.
- DIV family: DIV −7/2 → −3. REM −7/2 → −1. DIVU 100/7 → 14.
- Special cases: DIV 5/0 → 0xFFFFFFFF. REMU 5/0 → 5. DIV 0x80000000/−1 → 0x80000000. Each with `StallE` high for 1 cycle.
- Async reset asserted at BUSY cycle 10: outputs 0 immediately, `StallE`=0. After release, a new MUL 3×4 → 12 with the full normal latency.
